// File: rtl/sensor_hit_detector.sv
// sensor_hit_detector
// Front end for the whack-a-box hit sensors. Each GPIO line is optionally
// inverted, passed through a two-flop synchroniser, debounced and
// edge-detected. Rising edges are turned into one pending box address at a
// time, which the game FSM takes with a valid/ack handshake.
//
// Build option: define SENSOR_HEX_EN to build the 7-segment decoder for
// box_addr. Without it hex_display is held blank (all segments off).

module sensor_hit_detector #(
    parameter int N_SENSORS       = 3,
    parameter int ADDR_W          = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_SENSORS-1:0] sensor_in,
    output logic [N_SENSORS-1:0] sensor_level,
    output logic                 hit_valid,
    output logic [ADDR_W-1:0]    box_addr,
    input  logic                 hit_ack,
    output logic                 missed_hit,
    input  logic                 clr_missed,
    output logic [6:0]           hex_display
);

    // The counter only has to reach DEBOUNCE_CYCLES-1; keep at least one bit
    // so a debounce length of 1 still elaborates cleanly.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t                 state;
    logic [N_SENSORS-1:0]   sensor_pol;
    logic [N_SENSORS-1:0]   sync_q1;
    logic [N_SENSORS-1:0]   sync_q2;
    logic [CNT_W-1:0]       deb_cnt [N_SENSORS];
    logic [N_SENSORS-1:0]   level_d;
    logic [N_SENSORS-1:0]   rise;
    logic                   any_rise;
    logic                   extra_rise;
    logic                   drop_hit;
    logic [ADDR_W-1:0]      first_addr;

    // Polarity correction happens before the synchroniser so everything
    // downstream sees "1 = sensor hit".
    assign sensor_pol = (ACTIVE_LOW != 0) ? ~sensor_in : sensor_in;

    // Two-flop synchroniser for the asynchronous GPIO lines.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= sensor_pol;
            sync_q2 <= sync_q1;
        end
    end

    // Per-channel debounce: a level is accepted only after it has disagreed
    // with the current debounced level for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sensor_level <= '0;
            for (int i = 0; i < N_SENSORS; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SENSORS; i++) begin
                if (sync_q2[i] != sensor_level[i]) begin
                    if (deb_cnt[i] == CNT_MAX) begin
                        sensor_level[i] <= ~sensor_level[i];
                        deb_cnt[i]      <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Previous debounced level, used to turn 0->1 transitions into one-cycle pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_d <= '0;
        end else begin
            level_d <= sensor_level;
        end
    end

    assign rise       = sensor_level & ~level_d;
    assign any_rise   = |rise;
    assign extra_rise = |(rise & (rise - N_SENSORS'(1)));

    // Priority encoder: the lowest-index rising channel wins, reported 1-based.
    always_comb begin
        first_addr = '0;
        for (int i = N_SENSORS - 1; i >= 0; i--) begin
            if (rise[i]) begin
                first_addr = ADDR_W'(i + 1);
            end
        end
    end

    // A hit is lost when several channels rise together, or when a new one
    // rises while the previous hit is still waiting and not being taken.
    assign drop_hit = extra_rise | ((state == PEND) & ~hit_ack & any_rise);

    // Handshake FSM with registered outputs; missed_hit is sticky and a new
    // drop takes priority over a clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hit_valid  <= 1'b0;
            box_addr   <= '0;
            missed_hit <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_rise) begin
                        box_addr  <= first_addr;
                        hit_valid <= 1'b1;
                        state     <= PEND;
                    end
                end
                PEND: begin
                    if (hit_ack) begin
                        if (any_rise) begin
                            box_addr <= first_addr;
                        end else begin
                            hit_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    hit_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase

            if (drop_hit) begin
                missed_hit <= 1'b1;
            end else if (clr_missed) begin
                missed_hit <= 1'b0;
            end
        end
    end

`ifdef SENSOR_HEX_EN
    logic [3:0] hex_nib;

    generate
        if (ADDR_W >= 4) begin : g_nib_slice
            assign hex_nib = box_addr[3:0];
        end else begin : g_nib_pad
            assign hex_nib = {{(4 - ADDR_W){1'b0}}, box_addr};
        end
    endgenerate

    // Active-low 7-segment decode (gfedcba) of the low nibble of box_addr.
    always_comb begin
        hex_display = 7'b1111111;
        case (hex_nib)
            4'h0: hex_display = 7'b1000000;
            4'h1: hex_display = 7'b1111001;
            4'h2: hex_display = 7'b0100100;
            4'h3: hex_display = 7'b0110000;
            4'h4: hex_display = 7'b0011001;
            4'h5: hex_display = 7'b0010010;
            4'h6: hex_display = 7'b0000010;
            4'h7: hex_display = 7'b1111000;
            4'h8: hex_display = 7'b0000000;
            4'h9: hex_display = 7'b0010000;
            4'hA: hex_display = 7'b0001000;
            4'hB: hex_display = 7'b0000011;
            4'hC: hex_display = 7'b1000110;
            4'hD: hex_display = 7'b0100001;
            4'hE: hex_display = 7'b0000110;
            4'hF: hex_display = 7'b0001110;
            default: hex_display = 7'b1111111;
        endcase
    end
`else
    assign hex_display = 7'b1111111;
`endif

endmodule

// File: tb/tb_sensor_hit_detector.sv
// tb_sensor_hit_detector
// Two instances: dut_a is active-high, dut_b is active-low. Both are run in
// lockstep against a window-based reference model of debounce and handshake.

module tb_sensor_hit_detector;

    localparam int N  = 3;
    localparam int AW = 4;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  sensor_in_a, sensor_in_b;
    logic          hit_ack, clr_missed;
    logic [N-1:0]  sensor_level_a, sensor_level_b;
    logic          hit_valid_a, hit_valid_b;
    logic [AW-1:0] box_addr_a, box_addr_b;
    logic          missed_hit_a, missed_hit_b;
    logic [6:0]    hex_a, hex_b;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state, index 0 = dut_a, 1 = dut_b.
    logic [N-1:0]  m_hist [2][8];
    logic [N-1:0]  m_lvl [2];
    logic [N-1:0]  m_lvl_prev [2];
    logic          m_pend [2];
    logic [AW-1:0] m_addr [2];
    logic          m_missed [2];

    sensor_hit_detector #(.N_SENSORS(N), .ADDR_W(AW), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(0)) dut_a (
        .clk(clk), .reset(reset), .sensor_in(sensor_in_a), .sensor_level(sensor_level_a),
        .hit_valid(hit_valid_a), .box_addr(box_addr_a), .hit_ack(hit_ack),
        .missed_hit(missed_hit_a), .clr_missed(clr_missed), .hex_display(hex_a));

    sensor_hit_detector #(.N_SENSORS(N), .ADDR_W(AW), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1)) dut_b (
        .clk(clk), .reset(reset), .sensor_in(sensor_in_b), .sensor_level(sensor_level_b),
        .hit_valid(hit_valid_b), .box_addr(box_addr_b), .hit_ack(hit_ack),
        .missed_hit(missed_hit_b), .clr_missed(clr_missed), .hex_display(hex_b));

    always #5 clk = ~clk;

    // Expected 7-segment pattern for a box address.
    function automatic logic [6:0] exp_hex(input logic [3:0] a);
`ifdef SENSOR_HEX_EN
        logic [6:0] lut [16];
        lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return lut[a];
`else
        return (a == 4'hF) ? 7'h7F : 7'h7F;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic ack, input logic clr);
        sensor_in_a = a;
        sensor_in_b = b;
        hit_ack     = ack;
        clr_missed  = clr;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int j = 0; j < 8; j++) m_hist[d][j] = '0;
            m_lvl[d]      = '0;
            m_lvl_prev[d] = '0;
            m_pend[d]     = 1'b0;
            m_addr[d]     = '0;
            m_missed[d]   = 1'b0;
        end
    endtask

    // One clock edge of the reference model. m_hist[d][0] is the polarity-
    // corrected sample taken at the previous edge; a level flips once the D
    // samples older than that one all disagree with it.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            logic [N-1:0]  raw;
            logic [N-1:0]  rs;
            logic [N-1:0]  new_lvl;
            logic [AW-1:0] first;
            logic          drop;
            raw   = (d == 0) ? sensor_in_a : ~sensor_in_b;
            rs    = m_lvl[d] & ~m_lvl_prev[d];
            first = '0;
            for (int i = N - 1; i >= 0; i--) if (rs[i]) first = AW'(i + 1);
            drop = ($countones(rs) > 1) || (m_pend[d] && !hit_ack && rs != 0);
            if (!m_pend[d]) begin
                if (rs != 0) begin
                    m_pend[d] = 1'b1;
                    m_addr[d] = first;
                end
            end else if (hit_ack) begin
                if (rs != 0) m_addr[d] = first;
                else         m_pend[d] = 1'b0;
            end
            if (drop)            m_missed[d] = 1'b1;
            else if (clr_missed) m_missed[d] = 1'b0;
            new_lvl = m_lvl[d];
            for (int ch = 0; ch < N; ch++) begin
                logic all_diff;
                all_diff = 1'b1;
                for (int j = 1; j <= D; j++) if (m_hist[d][j][ch] == m_lvl[d][ch]) all_diff = 1'b0;
                if (all_diff) new_lvl[ch] = ~m_lvl[d][ch];
            end
            m_lvl_prev[d] = m_lvl[d];
            m_lvl[d]      = new_lvl;
            for (int j = 7; j >= 1; j--) m_hist[d][j] = m_hist[d][j-1];
            m_hist[d][0] = raw;
        end
    endtask

    task automatic check_all();
        checkOutput("level_a",  8'(sensor_level_a), 8'(m_lvl[0]));
        checkOutput("valid_a",  8'(hit_valid_a),    8'(m_pend[0]));
        checkOutput("addr_a",   8'(box_addr_a),     8'(m_addr[0]));
        checkOutput("missed_a", 8'(missed_hit_a),   8'(m_missed[0]));
        checkOutput("hex_a",    8'(hex_a),          8'(exp_hex(m_addr[0])));
        checkOutput("level_b",  8'(sensor_level_b), 8'(m_lvl[1]));
        checkOutput("valid_b",  8'(hit_valid_b),    8'(m_pend[1]));
        checkOutput("addr_b",   8'(box_addr_b),     8'(m_addr[1]));
        checkOutput("missed_b", 8'(missed_hit_b),   8'(m_missed[1]));
        checkOutput("hex_b",    8'(hex_b),          8'(exp_hex(m_addr[1])));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge();
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int  n;
        logic seen;
        logic [N-1:0] ra, rb;

        // Reset state
        reset = 1'b1;
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b0);
        model_reset();
        ticks(3);
        checkOutput("rst_valid", 8'(hit_valid_a), 8'd0);
        checkOutput("rst_addr",  8'(box_addr_a),  8'd0);
        checkOutput("rst_hex",   8'(hex_a),       8'(exp_hex(4'd0)));
        @(negedge clk) reset = 1'b0;

        // Active-low instance: line 2 goes low -> box 3
        applyStimulus(3'b000, 3'b011, 1'b0, 1'b0);
        n = 0;
        while (!hit_valid_b && n < 20) begin tick(); n++; end
        checkOutput("t6_valid_b", 8'(hit_valid_b), 8'd1);
        checkOutput("t6_addr_b",  8'(box_addr_b),  8'd3);
        checkOutput("t6_hex_b",   8'(hex_b),       8'(exp_hex(4'd3)));
        applyStimulus(3'b000, 3'b011, 1'b1, 1'b0);
        tick();
        applyStimulus(3'b000, 3'b011, 1'b0, 1'b0);
        ticks(8);

        // Debounce latency: capture at edge k, level at k+5, hit at k+6
        applyStimulus(3'b001, 3'b011, 1'b0, 1'b0);
        n = 0;
        do begin tick(); n++; end while (sensor_level_a != 3'b001 && n < 20);
        checkOutput("t2_level_lat", 8'(n), 8'd6);
        tick();
        checkOutput("t2_valid", 8'(hit_valid_a), 8'd1);
        checkOutput("t2_addr",  8'(box_addr_a),  8'd1);
        checkOutput("t2_hex",   8'(hex_a),       8'(exp_hex(4'd1)));
        applyStimulus(3'b001, 3'b011, 1'b1, 1'b0);
        tick();
        checkOutput("t2_ack_valid", 8'(hit_valid_a), 8'd0);
        checkOutput("t2_ack_hold",  8'(box_addr_a),  8'd1);
        applyStimulus(3'b000, 3'b011, 1'b0, 1'b0);
        ticks(10);

        // Glitch shorter than the debounce window
        applyStimulus(3'b001, 3'b011, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin tick(); seen |= hit_valid_a; end
        applyStimulus(3'b000, 3'b011, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin tick(); seen |= hit_valid_a | sensor_level_a[0]; end
        checkOutput("t3_no_hit", 8'(seen), 8'd0);

        // Two channels rise together
        applyStimulus(3'b110, 3'b011, 1'b0, 1'b0);
        n = 0;
        while (!hit_valid_a && n < 20) begin tick(); n++; end
        checkOutput("t4_addr",   8'(box_addr_a),   8'd2);
        checkOutput("t4_missed", 8'(missed_hit_a), 8'd1);
        applyStimulus(3'b110, 3'b011, 1'b0, 1'b1);
        tick();
        checkOutput("t4_clr", 8'(missed_hit_a), 8'd0);
        applyStimulus(3'b000, 3'b011, 1'b1, 1'b0);
        tick();
        applyStimulus(3'b000, 3'b011, 1'b0, 1'b0);
        ticks(10);

        // Pending hit not acked, then a second rise is dropped
        applyStimulus(3'b001, 3'b011, 1'b0, 1'b0);
        n = 0;
        while (!hit_valid_a && n < 20) begin tick(); n++; end
        checkOutput("t5_first", 8'(box_addr_a), 8'd1);
        applyStimulus(3'b101, 3'b011, 1'b0, 1'b0);
        ticks(8);
        checkOutput("t5_keep",   8'(box_addr_a),   8'd1);
        checkOutput("t5_missed", 8'(missed_hit_a), 8'd1);
        // Ack lands on the same edge as channel 1's rise (edge k+6)
        applyStimulus(3'b111, 3'b011, 1'b0, 1'b0);
        ticks(6);
        applyStimulus(3'b111, 3'b011, 1'b1, 1'b0);
        tick();
        checkOutput("t5_b2b_valid", 8'(hit_valid_a), 8'd1);
        checkOutput("t5_b2b_addr",  8'(box_addr_a),  8'd2);
        applyStimulus(3'b111, 3'b011, 1'b1, 1'b1);
        tick();
        applyStimulus(3'b000, 3'b011, 1'b0, 1'b0);
        ticks(10);

        // Reset mid-run with a pending hit, sensor held through release
        applyStimulus(3'b010, 3'b011, 1'b0, 1'b0);
        ticks(7);
        checkOutput("t1_pre_valid", 8'(hit_valid_a), 8'd1);
        reset = 1'b1;
        model_reset();
        #1;
        checkOutput("t1_rst_valid",  8'(hit_valid_a),    8'd0);
        checkOutput("t1_rst_addr",   8'(box_addr_a),     8'd0);
        checkOutput("t1_rst_missed", 8'(missed_hit_a),   8'd0);
        checkOutput("t1_rst_level",  8'(sensor_level_a), 8'd0);
        checkOutput("t1_rst_hex",    8'(hex_a),          8'(exp_hex(4'd0)));
        ticks(2);
        @(negedge clk) reset = 1'b0;
        n = 0;
        while (!hit_valid_a && n < 20) begin tick(); n++; end
        checkOutput("t1_valid", 8'(hit_valid_a), 8'd1);
        checkOutput("t1_addr",  8'(box_addr_a),  8'd2);

        // Randomised phase
        for (int it = 0; it < 250; it++) begin
            int hold;
            ra   = N'($urandom_range(0, 7));
            rb   = N'($urandom_range(0, 7));
            hold = $urandom_range(1, 7);
            for (int h = 0; h < hold; h++) begin
                applyStimulus(ra, rb, ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
                tick();
            end
            if (it % 60 == 59) begin
                reset = 1'b1;
                model_reset();
                #1;
                check_all();
                tick();
                @(negedge clk) reset = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
